bpsk_modulator: RTL and testbench
=================================

Name: bpsk_modulator

Overview:
- BPSK transmitter, the counterpart of the Costas-loop receiver chain.
- Accepts a byte stream over a valid/ready handshake, frames it as preamble, data and tail, and maps bits onto a continuous-phase carrier from an internal phase accumulator and sine LUT.
- Produces signed 8-bit samples at the 8 MHz system clock, directly compatible with the receiver's 8-bit `din`.

Parameters:
- PHASE_INC, 30'd53687091: carrier phase increment per clk (30-bit accumulator).
- SPS, 80: clk samples per symbol (100 kbaud at 8 MHz); legal range 2..1023.
- PREAMBLE_LEN, 32: preamble symbols, alternating 1,0,1,0..., starting with 1; legal range 1..255.
- TAIL_LEN, 8: trailing symbols of bit 0 after the last data byte; legal range 1..255.

Ports:
- clk  in  1  system clock, 8 MHz
- reset_n  in  1  asynchronous reset, active-low
- din  in  8  data byte, transmitted MSB first
- din_valid  in  1  din/din_last are valid
- din_last  in  1  qualifies din as the final byte of the frame
- din_ready  out  1  block accepts the byte this cycle
- dout  out  8  signed modulated sample
- dout_valid  out  1  high while a frame is being emitted
- sym_strobe  out  1  one-cycle pulse on the first dout sample of each symbol
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset_n low, async): FSM=IDLE, phase accumulator=0, all counters=0, dout=0, dout_valid=0, sym_strobe=0, busy=0, din_ready=0. Mid-frame reset abandons the frame immediately; no tail is sent.
- Phase accumulator: 30-bit, adds PHASE_INC every clk in every state and wraps modulo 2^30. The carrier is therefore phase-continuous across frames.
- Sine LUT: 256 entries, round(127*sin(2*pi*k/256)), addressed by phase[29:22]. Range is +-127, so negation never overflows.
- Mapping: bit 1 -> +LUT, bit 0 -> -LUT.
- Output pipeline: dout is registered. There are 2 clk of latency from accumulator value to dout; dout_valid and sym_strobe are delayed to match.
- FSM states: IDLE, PREAMBLE, DATA, TAIL.
- IDLE
  - din_ready=1 (combinational: state==IDLE or load point).
  - On din_valid: capture din into the shift register and din_last into a last flag; sample_cnt=0, sym_cnt=0; go to PREAMBLE.
  - dout=0, dout_valid=0.
- PREAMBLE
  - Emits PREAMBLE_LEN symbols of SPS samples each.
  - After the last sample of the last preamble symbol, go to DATA with bit_cnt=0.
- DATA
  - Emits shift-register bit 7, shifting left at each symbol end.
  - Load point: sample_cnt==SPS-1 and bit_cnt==7, with the last flag clear. din_ready=1 for that single cycle.
  - If din_valid at the load point: load the byte and last flag, continue in DATA.
  - If din_valid is low at the load point (underrun): go to TAIL.
  - If the last flag is set at byte end: go to TAIL; din_ready stays 0.
- TAIL: emits TAIL_LEN symbols of bit 0, then IDLE.
- Counters: sample_cnt counts 0..SPS-1 and wraps to 0 at symbol end. sym_strobe is asserted when sample_cnt==0 outside IDLE (pre-pipeline).
- Bytes offered while busy and not at a load point are not accepted (din_ready=0); the source holds them.
- din_last with a one-byte frame: preamble, 8 bits, tail.

Optional Feature:
- Macro: BPSK_DIFF_ENC_EN.
- Defined: in DATA, transmitted bit = data bit XOR previously transmitted bit. The reference is the last preamble bit (0 when PREAMBLE_LEN is even). This removes the receiver's 180-degree ambiguity.
- Preamble and tail are unaffected.
- Undefined: data bits are mapped directly.

Decomposition:
- Shared package bpsk_pkg:
  - FSM state typedef.
  - Constants: LUT_DEPTH=256, LUT_AMP=127, PHASE_W=30, SAMPLE_W=8.
- Sub-module bpsk_sine_lut: registered 256x8 signed ROM, one clk latency, address phase[29:22].
- FSM, counters and mapping stay in bpsk_modulator.

Test Plan:
- Single frame, din=8'hA5 with din_last=1, SPS=4, PREAMBLE_LEN=2, TAIL_LEN=1 -> busy for 44 clk.
  - dout symbol signs: +,-, then +,-,+,-,-,+,-,+, then -.
  - Exactly 11 sym_strobe pulses; din_ready high only in IDLE.
- Back-to-back bytes 8'h00, 8'hFF (last) with valid held -> din_ready pulses exactly once, at the last sample of byte 0. Data sign flips from - to + at symbol 8.
- Underrun: bytes 8'hF0 (not last), then din_valid low at the load point -> DATA ends, TAIL_LEN negative-sign symbols follow, then IDLE with dout=0.
- Phase continuity: PHASE_INC=2^22, SPS=8 -> LUT address increments by 1 every clk, including across symbol and frame boundaries. Within each symbol, |dout| follows the LUT exactly.
- reset_n low mid-DATA -> next edge, not clock: dout=0, busy=0, dout_valid=0. A new frame after release starts with preamble bit 1.
- BPSK_DIFF_ENC_EN defined, PREAMBLE_LEN=2, data 8'hFF -> transmitted bits 1,0,1,0,1,0,1,0, following preamble 1,0.

Source files
------------

// File: rtl/bpsk_pkg.sv
`default_nettype none
// ============================================================================
// bpsk_pkg : shared FSM state type and datapath constants for the BPSK modulator
// Rev 1.0
// ============================================================================
package bpsk_pkg;

   localparam int LUT_DEPTH = 256;
   localparam int LUT_AMP   = 127;
   localparam int PHASE_W   = 30;
   localparam int SAMPLE_W  = 8;
   localparam int LUT_AW    = $clog2(LUT_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_TAIL     = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/bpsk_sine_lut.sv
`default_nettype none
// ============================================================================
// bpsk_sine_lut : registered 256-entry signed sine ROM, round(127*sin), 1 clk
// Rev 1.0
// ============================================================================
module bpsk_sine_lut
   import bpsk_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [LUT_AW-1:0]          i_addr,
   output logic signed [SAMPLE_W-1:0] o_data
);

   localparam logic [6:0] c_PEAK = 7'(LUT_AMP);

   // Quarter-wave table; the other three quadrants follow by mirror and negation.
   function automatic logic [6:0] quarter(input logic [6:0] idx);
      logic [6:0] v;
      case (idx)
         7'd0:  v = 7'd0;    7'd1:  v = 7'd3;    7'd2:  v = 7'd6;    7'd3:  v = 7'd9;
         7'd4:  v = 7'd12;   7'd5:  v = 7'd16;   7'd6:  v = 7'd19;   7'd7:  v = 7'd22;
         7'd8:  v = 7'd25;   7'd9:  v = 7'd28;   7'd10: v = 7'd31;   7'd11: v = 7'd34;
         7'd12: v = 7'd37;   7'd13: v = 7'd40;   7'd14: v = 7'd43;   7'd15: v = 7'd46;
         7'd16: v = 7'd49;   7'd17: v = 7'd51;   7'd18: v = 7'd54;   7'd19: v = 7'd57;
         7'd20: v = 7'd60;   7'd21: v = 7'd63;   7'd22: v = 7'd65;   7'd23: v = 7'd68;
         7'd24: v = 7'd71;   7'd25: v = 7'd73;   7'd26: v = 7'd76;   7'd27: v = 7'd78;
         7'd28: v = 7'd81;   7'd29: v = 7'd83;   7'd30: v = 7'd85;   7'd31: v = 7'd88;
         7'd32: v = 7'd90;   7'd33: v = 7'd92;   7'd34: v = 7'd94;   7'd35: v = 7'd96;
         7'd36: v = 7'd98;   7'd37: v = 7'd100;  7'd38: v = 7'd102;  7'd39: v = 7'd104;
         7'd40: v = 7'd106;  7'd41: v = 7'd107;  7'd42: v = 7'd109;  7'd43: v = 7'd111;
         7'd44: v = 7'd112;  7'd45: v = 7'd113;  7'd46: v = 7'd115;  7'd47: v = 7'd116;
         7'd48: v = 7'd117;  7'd49: v = 7'd118;  7'd50: v = 7'd120;  7'd51: v = 7'd121;
         7'd52: v = 7'd122;  7'd53: v = 7'd122;  7'd54: v = 7'd123;  7'd55: v = 7'd124;
         7'd56: v = 7'd125;  7'd57: v = 7'd125;  7'd58: v = 7'd126;  7'd59: v = 7'd126;
         7'd60: v = 7'd126;  7'd61: v = 7'd127;  7'd62: v = 7'd127;  7'd63: v = 7'd127;
         default: v = c_PEAK;
      endcase
      return v;
   endfunction

   logic [6:0]                w_idx;
   logic signed [SAMPLE_W-1:0] w_mag;

   assign w_idx = i_addr[6] ? (7'd64 - {1'b0, i_addr[5:0]}) : {1'b0, i_addr[5:0]};
   assign w_mag = $signed({1'b0, quarter(w_idx)});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_data <= '0;
      end else begin
         o_data <= i_addr[7] ? -w_mag : w_mag;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bpsk_modulator.sv
`default_nettype none
// ============================================================================
// bpsk_modulator : framed BPSK transmitter (preamble/data/tail) on a phase-
// continuous carrier. Optional differential data encoding: BPSK_DIFF_ENC_EN.
// Rev 1.0
// ============================================================================
module bpsk_modulator
   import bpsk_pkg::*;
#(
   parameter logic [PHASE_W-1:0] PHASE_INC    = 30'd53687091,
   parameter int                 SPS          = 80,
   parameter int                 PREAMBLE_LEN = 32,
   parameter int                 TAIL_LEN     = 8
)(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [SAMPLE_W-1:0]        din,
   input  logic                       din_valid,
   input  logic                       din_last,
   output logic                       din_ready,
   output logic signed [SAMPLE_W-1:0] dout,
   output logic                       dout_valid,
   output logic                       sym_strobe,
   output logic                       busy
);

   localparam logic [9:0] c_SPS_LAST  = 10'(SPS - 1);
   localparam logic [7:0] c_PRE_LAST  = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0] c_TAIL_LAST = 8'(TAIL_LEN - 1);

   state_t                     r_state;
   logic [PHASE_W-1:0]         r_phase;
   logic [9:0]                 r_sample_cnt;
   logic [7:0]                 r_sym_cnt;
   logic [2:0]                 r_bit_cnt;
   logic [7:0]                 r_shift;
   logic                       r_last;
   logic                       r_bit_d;
   logic                       r_active_d;
   logic                       r_strobe_d;
   logic signed [SAMPLE_W-1:0] w_lut;
   logic                       w_active;
   logic                       w_sym_end;
   logic                       w_byte_end;
   logic                       w_load_pt;
   logic                       w_data_bit;
   logic                       w_tx_bit;

   assign w_active   = (r_state != ST_IDLE);
   assign w_sym_end  = (r_sample_cnt == c_SPS_LAST);
   assign w_byte_end = (r_state == ST_DATA) && w_sym_end && (r_bit_cnt == 3'd7);
   assign w_load_pt  = w_byte_end && !r_last;
   assign din_ready  = reset_n && (!w_active || w_load_pt);
   assign busy       = w_active;

`ifdef BPSK_DIFF_ENC_EN
   logic r_prev_bit;

   assign w_data_bit = r_shift[7] ^ r_prev_bit;

   // Tracks the last transmitted bit; the final preamble bit seeds the data reference.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev_bit <= 1'b0;
      end else if (w_active && w_sym_end) begin
         r_prev_bit <= w_tx_bit;
      end
   end
`else
   assign w_data_bit = r_shift[7];
`endif

   always_comb begin
      case (r_state)
         ST_PREAMBLE: w_tx_bit = ~r_sym_cnt[0];
         ST_DATA:     w_tx_bit = w_data_bit;
         default:     w_tx_bit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_sample_cnt <= '0;
         r_sym_cnt    <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_last       <= 1'b0;
      end else begin
         if (w_active) begin
            r_sample_cnt <= w_sym_end ? 10'd0 : r_sample_cnt + 10'd1;
         end
         case (r_state)
            ST_IDLE: begin
               if (din_valid) begin
                  r_shift      <= din;
                  r_last       <= din_last;
                  r_sample_cnt <= '0;
                  r_sym_cnt    <= '0;
                  r_state      <= ST_PREAMBLE;
               end
            end
            ST_PREAMBLE: begin
               if (w_sym_end) begin
                  if (r_sym_cnt == c_PRE_LAST) begin
                     r_sym_cnt <= '0;
                     r_bit_cnt <= '0;
                     r_state   <= ST_DATA;
                  end else begin
                     r_sym_cnt <= r_sym_cnt + 8'd1;
                  end
               end
            end
            ST_DATA: begin
               if (w_sym_end) begin
                  r_shift   <= {r_shift[6:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  // Byte boundary: chain the next byte only if offered, else drain via tail.
                  if (w_byte_end) begin
                     if (w_load_pt && din_valid) begin
                        r_shift <= din;
                        r_last  <= din_last;
                     end else begin
                        r_sym_cnt <= '0;
                        r_state   <= ST_TAIL;
                     end
                  end
               end
            end
            ST_TAIL: begin
               if (w_sym_end) begin
                  if (r_sym_cnt == c_TAIL_LAST) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_sym_cnt <= r_sym_cnt + 8'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   bpsk_sine_lut u_lut (
      .clk     (clk),
      .reset_n (reset_n),
      .i_addr  (r_phase[PHASE_W-1 -: LUT_AW]),
      .o_data  (w_lut)
   );

   // Control is delayed one stage to line up with the ROM output, then registered with dout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase    <= '0;
         r_bit_d    <= 1'b0;
         r_active_d <= 1'b0;
         r_strobe_d <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         sym_strobe <= 1'b0;
      end else begin
         r_phase    <= r_phase + PHASE_INC;
         r_bit_d    <= w_tx_bit;
         r_active_d <= w_active;
         r_strobe_d <= w_active && (r_sample_cnt == 10'd0);
         dout_valid <= r_active_d;
         sym_strobe <= r_strobe_d;
         dout       <= !r_active_d ? '0 : (r_bit_d ? w_lut : -w_lut);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bpsk_modulator.sv
`default_nettype none
// ============================================================================
// tb_bpsk_modulator : directed self-checking bench for bpsk_modulator
// Rev 1.0
// ============================================================================
module tb_bpsk_modulator;

   localparam int c_SPS = 4;

   logic              clk       = 1'b0;
   logic              reset_n   = 1'b0;
   logic [7:0]        din       = 8'h00;
   logic              din_valid = 1'b0;
   logic              din_last  = 1'b0;
   logic              din_ready;
   logic signed [7:0] dout;
   logic              dout_valid;
   logic              sym_strobe;
   logic              busy;

   int n_cmp    = 0;
   int n_err    = 0;
   int tb_edges = 0;

   string s_a5;
   string s_b2b;
   string s_und;

   always #5 clk = ~clk;

   bpsk_modulator #(
      .PHASE_INC    (30'd4194304),
      .SPS          (c_SPS),
      .PREAMBLE_LEN (2),
      .TAIL_LEN     (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_last   (din_last),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .sym_strobe (sym_strobe),
      .busy       (busy)
   );

   // Clock edges since reset release; with a 2^22 increment this is the LUT address.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) tb_edges <= 0;
      else          tb_edges <= tb_edges + 1;
   end

   function automatic int lut_ref(input int a);
      real r;
      r = 127.0 * $sin(2.0 * 3.14159265358979 * a / 256.0);
      if (r >= 0.0) return $rtoi(r + 0.5);
      return -$rtoi(0.5 - r);
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers nb bytes (b0 then b1), then watches the whole frame sample by sample.
   task automatic run_frame(input string tag, input string bits,
                            input logic [7:0] b0, input logic l0,
                            input logic [7:0] b1, input logic l1,
                            input int nb, input int exp_pulses);
      int   n_samp;
      int   idx;
      int   busy_cnt;
      int   strb_cnt;
      int   pulses;
      int   lv;
      bit   hs;
      bit   in_frame;
      bit   exp_bit;
      logic signed [31:0] exp_d;
      n_samp   = bits.len() * c_SPS;
      busy_cnt = 0;
      strb_cnt = 0;
      pulses   = 0;
      idx      = 0;
      chk({tag, "/idle_ready"}, din_ready, 1);
      din       = b0;
      din_last  = l0;
      din_valid = 1'b1;
      for (int k = -1; k < n_samp + 4; k++) begin
         if (k >= 0) begin
            in_frame = (k >= 2) && (k < n_samp + 2);
            chk({tag, "/busy"}, busy, k < n_samp);
            chk({tag, "/dout_valid"}, dout_valid, in_frame);
            chk({tag, "/sym_strobe"}, sym_strobe, in_frame && ((k - 2) % c_SPS == 0));
            if (in_frame) begin
               exp_bit = (bits[(k - 2) / c_SPS] == 8'h31);
               lv      = lut_ref((tb_edges - 2) % 256);
               exp_d   = exp_bit ? lv : -lv;
            end else begin
               exp_d = 0;
            end
            chk({tag, "/dout"}, dout, exp_d);
            if (busy)              busy_cnt++;
            if (sym_strobe)        strb_cnt++;
            if (busy && din_ready) pulses++;
         end
         hs = din_valid && din_ready;
         step();
         if (hs) begin
            idx++;
            if (idx < nb) begin
               din      = b1;
               din_last = l1;
            end else begin
               din_valid = 1'b0;
               din_last  = 1'b0;
            end
         end
      end
      chk({tag, "/busy_cycles"}, busy_cnt, n_samp);
      chk({tag, "/strobe_count"}, strb_cnt, bits.len());
      chk({tag, "/ready_pulses"}, pulses, exp_pulses);
      chk({tag, "/end_ready"}, din_ready, 1);
      chk({tag, "/end_dout"}, dout, 0);
   endtask

   initial begin
`ifdef BPSK_DIFF_ENC_EN
      s_a5  = "10110001100";
      s_b2b = "1000000000101010100";
      s_und = "10101000000";
`else
      s_a5  = "10101001010";
      s_b2b = "1000000000111111110";
      s_und = "10111100000";
`endif
      // Reset state while held
      repeat (3) @(posedge clk);
      #1;
      chk("rst/dout", dout, 0);
      chk("rst/dout_valid", dout_valid, 0);
      chk("rst/sym_strobe", sym_strobe, 0);
      chk("rst/busy", busy, 0);
      chk("rst/din_ready", din_ready, 0);
      #2 reset_n = 1'b1;
      step();
      chk("idle/din_ready", din_ready, 1);
      chk("idle/dout", dout, 0);

      // Single-byte frame with din_last
      run_frame("a5", s_a5, 8'hA5, 1'b1, 8'h00, 1'b0, 1, 0);
      repeat (3) step();
      chk("gap/dout", dout, 0);
      chk("gap/busy", busy, 0);

      // Back-to-back bytes with valid held
      run_frame("b2b", s_b2b, 8'h00, 1'b0, 8'hFF, 1'b1, 2, 1);

      // Underrun at the load point
      run_frame("under", s_und, 8'hF0, 1'b0, 8'h00, 1'b0, 1, 1);

      // Asynchronous reset in the middle of DATA
      din       = 8'hA5;
      din_last  = 1'b1;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      din_last  = 1'b0;
      repeat (20) step();
      chk("mid/busy_before", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid/dout", dout, 0);
      chk("mid/busy", busy, 0);
      chk("mid/dout_valid", dout_valid, 0);
      chk("mid/sym_strobe", sym_strobe, 0);
      chk("mid/din_ready", din_ready, 0);
      step();
      #2 reset_n = 1'b1;
      step();
      run_frame("post_rst", s_a5, 8'hA5, 1'b1, 8'h00, 1'b0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
